// File: rtl/frame_write_fsm.sv
// rtl/frame_write_fsm.sv - ping-pong frame bank write sequencer fed by a valid/ready word source
//
// Purpose: after start_data_FSM, pulls WORDS_PER_FRAME words per frame from the
// upstream source and writes them into the bank not being displayed. Each
// switch_mode pulse moves on to the next frame and toggles the write bank. A
// swap that arrives before the frame is complete drops that frame and raises
// underrun.
//
// Optional feature: define LOOP_VIDEO_EN to restart at frame 0 after the last
// frame instead of stopping in the terminal END state.
//
// Ports:
//   CLK_40          in   clock
//   reset           in   synchronous, active-high
//   start_data_FSM  in   pulse, (re)starts the video from frame 0
//   switch_mode     in   pulse, bank swap
//   src_data/src_valid/src_ready   upstream word handshake
//   wr_en_b1/wr_en_b2/wr_addr/wr_data  bank write port (one cycle after handshake)
//   frame_done      out  pulse with the last write of a frame
//   underrun        out  pulse, swap arrived before frame completion
//   video_end       out  level, all frames loaded
//   frame_idx       out  frame currently being loaded
module frame_write_fsm #(
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_FRAME = 60000,
    parameter int NUM_FRAMES      = 6572,
    parameter int FRAME_W         = 13
) (
    input  logic               CLK_40,
    input  logic               reset,
    input  logic               start_data_FSM,
    input  logic               switch_mode,
    input  logic [DATA_W-1:0]  src_data,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               wr_en_b1,
    output logic               wr_en_b2,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               frame_done,
    output logic               underrun,
    output logic               video_end,
    output logic [FRAME_W-1:0] frame_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_END
    } state_t;

    localparam logic [ADDR_W-1:0]  LAST_WORD  = ADDR_W'(WORDS_PER_FRAME - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);

    state_t             state, state_n;
    logic [ADDR_W-1:0]  word_cnt, word_cnt_n;
    logic [FRAME_W-1:0] frame_idx_n;
    // 1 selects bank 1, 0 selects bank 2 (the bank written first after a start)
    logic               wr_sel_b1, wr_sel_b1_n;

    logic hs;
    logic last_word;
    logic last_frame;
    logic do_advance;

    assign src_ready  = (state == S_LOAD);
    assign video_end  = (state == S_END);
    assign hs         = src_ready & src_valid;
    assign last_word  = (word_cnt == LAST_WORD);
    assign last_frame = (frame_idx == LAST_FRAME);
    // Swap only matters while a video is being loaded, and a simultaneous
    // start request takes priority over it.
    assign do_advance = switch_mode & ~start_data_FSM &
                        ((state == S_LOAD) | (state == S_DONE));

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state     <= S_IDLE;
            word_cnt  <= '0;
            frame_idx <= '0;
            wr_sel_b1 <= 1'b0;
        end else begin
            state     <= state_n;
            word_cnt  <= word_cnt_n;
            frame_idx <= frame_idx_n;
            wr_sel_b1 <= wr_sel_b1_n;
        end
    end

    always_comb begin
        state_n     = state;
        word_cnt_n  = word_cnt;
        frame_idx_n = frame_idx;
        wr_sel_b1_n = wr_sel_b1;
        if (start_data_FSM) begin
            state_n     = S_LOAD;
            word_cnt_n  = '0;
            frame_idx_n = '0;
            wr_sel_b1_n = 1'b0;
        end else if (do_advance) begin
            // Covers the normal swap from DONE, the aborted frame in LOAD,
            // and a swap coinciding with the last-word handshake.
            word_cnt_n = '0;
            if (last_frame) begin
`ifdef LOOP_VIDEO_EN
                state_n     = S_LOAD;
                frame_idx_n = '0;
                wr_sel_b1_n = ~wr_sel_b1;
`else
                state_n     = S_END;
`endif
            end else begin
                state_n     = S_LOAD;
                frame_idx_n = frame_idx + 1'b1;
                wr_sel_b1_n = ~wr_sel_b1;
            end
        end else if (hs) begin
            if (last_word) begin
                state_n    = S_DONE;
                word_cnt_n = '0;
            end else begin
                word_cnt_n = word_cnt + 1'b1;
            end
        end
    end

    // Write port and pulse outputs, one cycle behind the handshake. A word
    // accepted in the same cycle as a restart or swap is still written to the
    // bank that was selected when it was accepted.
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            wr_en_b1   <= 1'b0;
            wr_en_b2   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            wr_en_b1   <= hs & wr_sel_b1;
            wr_en_b2   <= hs & ~wr_sel_b1;
            frame_done <= hs & last_word;
            underrun   <= switch_mode & ~start_data_FSM & (state == S_LOAD) &
                          ~(hs & last_word);
            if (hs) begin
                wr_addr <= word_cnt;
                wr_data <= src_data;
            end else begin
                wr_addr <= '0;
                wr_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_frame_write_fsm.sv
// tb/tb_frame_write_fsm.sv - directed self-checking bench for frame_write_fsm
module tb_frame_write_fsm;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int WPF    = 4;
    localparam int NF     = 3;
    localparam int FRAME_W = 13;

    logic               CLK_40 = 1'b0;
    logic               reset;
    logic               start_data_FSM;
    logic               switch_mode;
    logic [DATA_W-1:0]  src_data;
    logic               src_valid;
    logic               src_ready;
    logic               wr_en_b1;
    logic               wr_en_b2;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               frame_done;
    logic               underrun;
    logic               video_end;
    logic [FRAME_W-1:0] frame_idx;

    int compared = 0;
    int mismatched = 0;

    frame_write_fsm #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS_PER_FRAME(WPF),
        .NUM_FRAMES(NF), .FRAME_W(FRAME_W)
    ) dut (
        .CLK_40(CLK_40), .reset(reset), .start_data_FSM(start_data_FSM),
        .switch_mode(switch_mode), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .wr_en_b1(wr_en_b1), .wr_en_b2(wr_en_b2),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
        .underrun(underrun), .video_end(video_end), .frame_idx(frame_idx)
    );

    always #12.5 CLK_40 = ~CLK_40;

    task automatic tick();
        @(posedge CLK_40);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the complete write port and pulse outputs in one go.
    task automatic chk_wr(input string tag, input logic b1, input logic b2,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic fd, input logic ur, input logic rdy);
        chk({tag, ".wr_en_b1"}, {31'd0, wr_en_b1}, {31'd0, b1});
        chk({tag, ".wr_en_b2"}, {31'd0, wr_en_b2}, {31'd0, b2});
        if (b1 | b2) begin
            chk({tag, ".wr_addr"}, {16'd0, wr_addr}, {16'd0, addr});
            chk({tag, ".wr_data"}, {24'd0, wr_data}, {24'd0, data});
        end
        chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, fd});
        chk({tag, ".underrun"}, {31'd0, underrun}, {31'd0, ur});
        chk({tag, ".src_ready"}, {31'd0, src_ready}, {31'd0, rdy});
    endtask

    task automatic chk_idx(input string tag, input int idx, input logic vend);
        chk({tag, ".frame_idx"}, {19'd0, frame_idx}, idx);
        chk({tag, ".video_end"}, {31'd0, video_end}, {31'd0, vend});
    endtask

    initial begin
        reset = 1'b1;
        start_data_FSM = 1'b0;
        switch_mode = 1'b0;
        src_data = '0;
        src_valid = 1'b0;
        tick();
        tick();
        chk_wr("reset", 0, 0, 0, 0, 0, 0, 0);
        chk_idx("reset", 0, 0);
        chk("reset.wr_addr", {16'd0, wr_addr}, 0);
        chk("reset.wr_data", {24'd0, wr_data}, 0);

        // Test 1: frame 0 into bank 2
        reset = 1'b0;
        start_data_FSM = 1'b1;
        tick();
        start_data_FSM = 1'b0;
        chk_wr("t1.start", 0, 0, 0, 0, 0, 0, 1);
        chk_idx("t1.start", 0, 0);
        src_valid = 1'b1;
        for (int i = 0; i < WPF; i++) begin
            src_data = 8'hA0 + 8'(i);
            tick();
            chk_wr($sformatf("t1.w%0d", i), 0, 1, 16'(i), 8'hA0 + 8'(i),
                   i == WPF - 1, 0, i != WPF - 1);
        end
        src_valid = 1'b0;
        tick();
        chk_wr("t1.done", 0, 0, 0, 0, 0, 0, 0);

        // Test 2: swap, frame 1 into bank 1, then swap back to bank 2
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
        chk_wr("t2.swap", 0, 0, 0, 0, 0, 0, 1);
        chk_idx("t2.swap", 1, 0);
        src_valid = 1'b1;
        for (int i = 0; i < WPF; i++) begin
            src_data = 8'hB0 + 8'(i);
            tick();
            chk_wr($sformatf("t2.w%0d", i), 1, 0, 16'(i), 8'hB0 + 8'(i),
                   i == WPF - 1, 0, i != WPF - 1);
        end
        src_valid = 1'b0;
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
        chk_wr("t2.swap2", 0, 0, 0, 0, 0, 0, 1);
        chk_idx("t2.swap2", 2, 0);
        src_valid = 1'b1;
        src_data = 8'hC0;
        tick();
        chk_wr("t2.back_b2", 0, 1, 0, 8'hC0, 0, 0, 1);

        // Test 3: src_valid alternating, addresses stay contiguous
        for (int i = 1; i < WPF; i++) begin
            src_valid = 1'b0;
            src_data = 8'hEE;
            tick();
            chk_wr($sformatf("t3.stall%0d", i), 0, 0, 0, 0, 0, 0, 1);
            src_valid = 1'b1;
            src_data = 8'hC0 + 8'(i);
            tick();
            chk_wr($sformatf("t3.w%0d", i), 0, 1, 16'(i), 8'hC0 + 8'(i),
                   i == WPF - 1, 0, i != WPF - 1);
        end
        src_valid = 1'b0;

        // Test 5: swap after the last frame
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
`ifdef LOOP_VIDEO_EN
        chk_wr("t5.loop", 0, 0, 0, 0, 0, 0, 1);
        chk_idx("t5.loop", 0, 0);
        src_valid = 1'b1;
        src_data = 8'h50;
        tick();
        src_valid = 1'b0;
        chk_wr("t5.loop_wr", 1, 0, 0, 8'h50, 0, 0, 1);
`else
        chk_wr("t5.end", 0, 0, 0, 0, 0, 0, 0);
        chk_idx("t5.end", 2, 1);
        switch_mode = 1'b1;
        src_valid = 1'b1;
        tick();
        switch_mode = 1'b0;
        src_valid = 1'b0;
        chk_wr("t5.end_sw", 0, 0, 0, 0, 0, 0, 0);
        chk_idx("t5.end_sw", 2, 1);
`endif

        // Test 4: restart, two words, then early swap -> underrun
        start_data_FSM = 1'b1;
        tick();
        start_data_FSM = 1'b0;
        chk_wr("t4.restart", 0, 0, 0, 0, 0, 0, 1);
        chk_idx("t4.restart", 0, 0);
        src_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            src_data = 8'h40 + 8'(i);
            tick();
            chk_wr($sformatf("t4.w%0d", i), 0, 1, 16'(i), 8'h40 + 8'(i), 0, 0, 1);
        end
        src_valid = 1'b0;
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
        chk_wr("t4.underrun", 0, 0, 0, 0, 0, 1, 1);
        chk_idx("t4.underrun", 1, 0);
        src_valid = 1'b1;
        src_data = 8'h60;
        tick();
        chk_wr("t4.next", 1, 0, 0, 8'h60, 0, 0, 1);

        // Last-word handshake together with swap: frame completes, next frame loads
        for (int i = 1; i < WPF; i++) begin
            src_data = 8'h60 + 8'(i);
            switch_mode = (i == WPF - 1);
            tick();
            chk_wr($sformatf("tb.w%0d", i), 1, 0, 16'(i), 8'h60 + 8'(i),
                   i == WPF - 1, 0, 1);
        end
        switch_mode = 1'b0;
        chk_idx("tb.last_sw", 2, 0);
        src_data = 8'h70;
        tick();
        chk_wr("tb.next_b2", 0, 1, 0, 8'h70, 0, 0, 1);

        // start and switch together: start wins, no underrun
        src_valid = 1'b0;
        start_data_FSM = 1'b1;
        switch_mode = 1'b1;
        tick();
        start_data_FSM = 1'b0;
        switch_mode = 1'b0;
        chk_wr("tb.start_sw", 0, 0, 0, 0, 0, 0, 1);
        chk_idx("tb.start_sw", 0, 0);
        src_valid = 1'b1;
        src_data = 8'h80;
        tick();
        chk_wr("tb.start_wr", 0, 1, 0, 8'h80, 0, 0, 1);

        // Test 6: reset mid-LOAD, then swap ignored in IDLE
        src_data = 8'h81;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_wr("t6.reset", 0, 0, 0, 0, 0, 0, 0);
        chk_idx("t6.reset", 0, 0);
        chk("t6.reset.wr_addr", {16'd0, wr_addr}, 0);
        chk("t6.reset.wr_data", {24'd0, wr_data}, 0);
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
        chk_wr("t6.idle_sw", 0, 0, 0, 0, 0, 0, 0);
        chk_idx("t6.idle_sw", 0, 0);
        tick();
        chk_wr("t6.idle_valid", 0, 0, 0, 0, 0, 0, 0);
        src_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
